// File: rtl/seg_display_scan.sv
// seg_display_scan
// Time-multiplexed seven-segment driver for the debug panel. It shows DIGITS
// hex nibbles, and digit 0 is the rightmost digit. Each digit is lit for
// PRESCALE cycles and is followed by GAP_CYCLES all-dark cycles.
//
// New values are staged in a pending register. They are copied into the
// displayed (active) register only at a frame wrap, or on any cycle while the
// display is off, so a frame is never torn.
//
// Optional feature: define DISPLAY_LZ_BLANK_EN to enable leading-zero
// suppression.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   enable_i     scan enable; low forces the display dark
//   load_i       capture strobe for bcds_i / dp_i
//   bcds_i       nibble i at [4i+3:4i]
//   dp_i         decimal point per digit
//   sel_led_o    one-hot digit select (polarity per ACTIVE_LOW_OUT)
//   led_value_o  {dp,g,f,e,d,c,b,a} (polarity per ACTIVE_LOW_OUT)
//   digit_idx_o  index of the digit currently lit
//   frame_done_o one-cycle pulse as the last digit's SHOW period ends
module seg_display_scan #(
    parameter int DIGITS         = 8,
    parameter int PRESCALE       = 100000,
    parameter int GAP_CYCLES     = 0,
    parameter bit ACTIVE_LOW_OUT = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      load_i,
    input  logic [4*DIGITS-1:0]       bcds_i,
    input  logic [DIGITS-1:0]         dp_i,
    output logic [DIGITS-1:0]         sel_led_o,
    output logic [7:0]                led_value_o,
    output logic [$clog2(DIGITS)-1:0] digit_idx_o,
    output logic                      frame_done_o
);

    localparam int IW   = $clog2(DIGITS);
    localparam int CMAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

    localparam logic [CW-1:0] P_TC = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] G_TC = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    localparam logic [DIGITS-1:0] SEL_POL = {DIGITS{ACTIVE_LOW_OUT}};
    localparam logic [7:0]        SEG_POL = {8{ACTIVE_LOW_OUT}};

    typedef enum logic [1:0] {S_OFF, S_SHOW, S_GAP} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d, idx_nxt;
    logic                   fd_q, fd_d;

    logic [DIGITS-1:0][3:0] pend_bcd_q, pend_bcd_d, act_bcd_q, act_bcd_d;
    logic [DIGITS-1:0]      pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                   xfer;

    logic [DIGITS-1:0]      blank;
    logic [DIGITS-1:0]      sel_raw, sel_d, sel_q;
    logic [7:0]             seg_raw, seg_d, seg_q;
    logic                   lit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign idx_nxt = (idx_q == LAST) ? '0 : idx_q + 1'b1;

    // Scan FSM. cnt_q is shared by the SHOW and GAP periods.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        fd_d    = 1'b0;
        case (state_q)
            S_OFF: begin
                cnt_d = '0;
                idx_d = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == P_TC) begin
                    cnt_d = '0;
                    fd_d  = (idx_q == LAST);
                    if (GAP_CYCLES > 0) state_d = S_GAP;
                    else                idx_d   = idx_nxt;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == G_TC) begin
                    cnt_d   = '0;
                    state_d = S_SHOW;
                    idx_d   = idx_nxt;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase
        // Enable low overrides everything, and the frame pulse is suppressed.
        if (!enable_i) begin
            state_d = S_OFF;
            cnt_d   = '0;
            idx_d   = '0;
            fd_d    = 1'b0;
        end
    end

    // The frame_done cycle is the transfer cycle. If a load lands in that
    // same cycle, it bypasses pending so the next frame carries it. The
    // display decodes from the post-transfer value. This matters when
    // GAP_CYCLES is 0, because digit 0 is then already in SHOW during the
    // frame_done cycle.
    assign xfer       = (state_q == S_OFF) || fd_q;
    assign pend_bcd_d = load_i ? bcds_i : pend_bcd_q;
    assign pend_dp_d  = load_i ? dp_i   : pend_dp_q;
    assign act_bcd_d  = xfer ? pend_bcd_d : act_bcd_q;
    assign act_dp_d   = xfer ? pend_dp_d  : act_dp_q;

`ifdef DISPLAY_LZ_BLANK_EN
    // Walk down from the most significant digit. A digit is blanked while it
    // and every digit above it are a zero nibble with no dp. Digit 0 is
    // never blanked.
    logic run;
    always_comb begin
        blank = '0;
        run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run      = run & (act_bcd_d[i] == 4'h0) & ~act_dp_d[i];
            blank[i] = run;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        lit     = (state_q == S_SHOW) && !blank[idx_q];
        sel_raw = '0;
        seg_raw = '0;
        if (lit) begin
            sel_raw[idx_q] = 1'b1;
            seg_raw        = {act_dp_d[idx_q], hex7(act_bcd_d[idx_q])};
        end
        sel_d = sel_raw ^ SEL_POL;
        seg_d = seg_raw ^ SEG_POL;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            idx_q       <= '0;
            fd_q        <= 1'b0;
            pend_bcd_q  <= '0;
            pend_dp_q   <= '0;
            act_bcd_q   <= '0;
            act_dp_q    <= '0;
            sel_q       <= SEL_POL;
            seg_q       <= SEG_POL;
            digit_idx_o <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            fd_q        <= fd_d;
            pend_bcd_q  <= pend_bcd_d;
            pend_dp_q   <= pend_dp_d;
            act_bcd_q   <= act_bcd_d;
            act_dp_q    <= act_dp_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
            digit_idx_o <= idx_q;
        end
    end

    assign sel_led_o    = sel_q;
    assign led_value_o  = seg_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan.
// Configuration: DIGITS=4, PRESCALE=3, GAP_CYCLES=1, active-low outputs.
// Outputs are sampled 1 time unit after each rising edge.
// cyc counts edges from the point where enable is first raised.
module tb_seg_display_scan;

`ifdef DISPLAY_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, enable, load;
    logic [15:0] bcds;
    logic [3:0]  dp;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic [1:0]  idx;
    logic        fd;

    int cyc     = 0;
    int n_chk   = 0;
    int n_fail  = 0;

    seg_display_scan #(
        .DIGITS(4), .PRESCALE(3), .GAP_CYCLES(1), .ACTIVE_LOW_OUT(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .load_i(load),
        .bcds_i(bcds), .dp_i(dp), .sel_led_o(sel), .led_value_o(seg),
        .digit_idx_o(idx), .frame_done_o(fd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; bcds = '0; dp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", 32'(sel), 32'hF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_idx", 32'(idx), 32'h0);
        chk("rst_fd",  32'(fd),  32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("off_sel", 32'(sel), 32'hF);

        // Scan start and digit timing.
        enable = 1'b1; cyc = 0;
        tick();     chk("c1_sel", 32'(sel), 32'hF);
        tick();     chk("c2_sel", 32'(sel), 32'hE);
                    chk("c2_seg", 32'(seg), 32'hC0);
                    chk("c2_idx", 32'(idx), 32'h0);
        to_cyc(4);  chk("c4_sel", 32'(sel), 32'hE);
        to_cyc(5);  chk("c5_gap_sel", 32'(sel), 32'hF);
                    chk("c5_gap_seg", 32'(seg), 32'hFF);
        to_cyc(6);  chk("c6_sel", 32'(sel), LZ ? 32'hF : 32'hD);
                    chk("c6_idx", 32'(idx), 32'h1);
        to_cyc(15); chk("c15_fd", 32'(fd), 32'h0);
        to_cyc(16); chk("c16_fd", 32'(fd), 32'h1);
                    chk("c16_sel", 32'(sel), LZ ? 32'hF : 32'h7);
        to_cyc(17); chk("c17_fd", 32'(fd), 32'h0);
        to_cyc(18); chk("c18_sel", 32'(sel), 32'hE);

        // Mid-frame load must wait for the next frame.
        to_cyc(20); load = 1'b1; bcds = 16'h1A80; dp = 4'b0100;
        tick();     load = 1'b0; bcds = 16'h0000; dp = 4'b0000;
        to_cyc(22); chk("old_d1_sel", 32'(sel), LZ ? 32'hF : 32'hD);
                    chk("old_d1_seg", 32'(seg), LZ ? 32'hFF : 32'hC0);
        to_cyc(30); chk("old_d3_seg", 32'(seg), LZ ? 32'hFF : 32'hC0);
        to_cyc(32); chk("c32_fd", 32'(fd), 32'h1);
        to_cyc(34); chk("new_d0_sel", 32'(sel), 32'hE);
                    chk("new_d0_seg", 32'(seg), 32'hC0);
        to_cyc(38); chk("new_d1_sel", 32'(sel), 32'hD);
                    chk("new_d1_seg", 32'(seg), 32'h80);
        to_cyc(42); chk("new_d2_sel", 32'(sel), 32'hB);
                    chk("new_d2_seg", 32'(seg), 32'h08);
        to_cyc(46); chk("new_d3_sel", 32'(sel), 32'h7);
                    chk("new_d3_seg", 32'(seg), 32'hF9);

        // Load exactly on the frame_done cycle takes effect with no lag.
        to_cyc(48); chk("c48_fd", 32'(fd), 32'h1);
                    load = 1'b1; bcds = 16'h0005;
        tick();     load = 1'b0; bcds = 16'h0000;
        to_cyc(50); chk("byp_d0_seg", 32'(seg), 32'h92);
        to_cyc(54); chk("byp_d1_sel", 32'(sel), LZ ? 32'hF : 32'hD);
                    chk("byp_d1_seg", 32'(seg), LZ ? 32'hFF : 32'hC0);

        // 0050: leading zeros dark only with suppression enabled.
        to_cyc(56); load = 1'b1; bcds = 16'h0050;
        tick();     load = 1'b0; bcds = 16'h0000;
        to_cyc(64); chk("c64_fd", 32'(fd), 32'h1);
        to_cyc(66); chk("lz_d0_seg", 32'(seg), 32'hC0);
        to_cyc(70); chk("lz_d1_sel", 32'(sel), 32'hD);
                    chk("lz_d1_seg", 32'(seg), 32'h92);
        to_cyc(74); chk("lz_d2_sel", 32'(sel), LZ ? 32'hF : 32'hB);
                    chk("lz_d2_seg", 32'(seg), LZ ? 32'hFF : 32'hC0);
        to_cyc(78); chk("lz_d3_sel", 32'(sel), LZ ? 32'hF : 32'h7);

        // Drop enable during digit 2 SHOW, then restart.
        to_cyc(89); enable = 1'b0;
        to_cyc(90); chk("drop_c90_idx", 32'(idx), 32'h2);
        to_cyc(91); chk("drop_sel", 32'(sel), 32'hF);
                    chk("drop_seg", 32'(seg), 32'hFF);
                    chk("drop_idx", 32'(idx), 32'h0);
                    chk("drop_fd",  32'(fd),  32'h0);
        to_cyc(93); enable = 1'b1;
        to_cyc(94); chk("re_c94_sel", 32'(sel), 32'hF);
        to_cyc(95); chk("re_c95_sel", 32'(sel), 32'hE);
        to_cyc(96); chk("re_c96_fd", 32'(fd), 32'h0);
        to_cyc(97); chk("re_c97_sel", 32'(sel), 32'hE);

        // Async reset during GAP clears the outputs and both capture registers.
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel), 32'hF);
        chk("arst_seg", 32'(seg), 32'hFF);
        chk("arst_idx", 32'(idx), 32'h0);
        tick();     rst_n = 1'b1;
        to_cyc(100); chk("post_d0_sel", 32'(sel), 32'hE);
                     chk("post_d0_seg", 32'(seg), 32'hC0);
        to_cyc(104); chk("post_d1_sel", 32'(sel), LZ ? 32'hF : 32'hD);
                     chk("post_d1_seg", 32'(seg), LZ ? 32'hFF : 32'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Parametrised, time-multiplexed seven-segment display driver for the FPGA debug panel. It displays DIGITS hex nibbles: the left digits carry the PC and the right digits carry the probed register, instruction, ALU or store-data value. Compared with the fixed 8-digit display it adds:
- a configurable refresh prescaler;
- an inter-digit blanking gap against ghosting;
- per-digit decimal points;
- tear-free frame-synchronous loading;
- optional leading-zero suppression.

## Interface
- DIGITS, 8, number of digits, 2..16
- PRESCALE, 100000, clock cycles each digit is lit, ≥1
- GAP_CYCLES, 0, all-dark cycles between digits; 0 removes the gap
- ACTIVE_LOW_OUT, 1, 1 = anode and segment outputs active-low; 0 = active-high
- clock  in  1  system clock (single clock domain)
- reset  in  1  asynchronous, active-low reset
- enable  in  1  scan enable; low = display dark
- load  in  1  capture strobe for bcds/dp
- bcds  in  4*DIGITS  nibble i at [4i+3:4i]; digit 0 is rightmost
- dp  in  DIGITS  decimal point per digit
- sel_led  out  DIGITS  one-hot digit select, polarity per ACTIVE_LOW_OUT
- led_value  out  8  {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW_OUT
- digit_idx  out  $clog2(DIGITS)  index of the digit currently lit
- frame_done  out  1  one-cycle pulse when the last digit's SHOW period ends

## Operation
- Two capture registers:
  - pending: loaded from bcds/dp on any cycle with load=1.
  - active: the values being displayed.
- pending→active transfer happens at each frame wrap and on every cycle in OFF. If load=1 on the transfer cycle, active takes bcds/dp directly (bypass).
- FSM states: OFF, SHOW, GAP.
  - OFF: all digits dark; prescaler=0, digit_idx=0. enable=1 → SHOW.
  - SHOW: selected digit lit; prescaler counts 0..PRESCALE-1. At terminal count → GAP if GAP_CYCLES>0, else SHOW for the next digit.
  - GAP: all digits dark for GAP_CYCLES, then SHOW for the next digit.
  - enable=0 in any state → OFF on the next clock.
- Next digit = digit_idx+1; wraps from DIGITS-1 to 0.
- frame_done pulses for one cycle when digit DIGITS-1 leaves SHOW.
- Hex decode uses standard 0-F glyphs. Active-high values: 0=0x3F, 1=0x06, 8=0x7F, A=0x77, F=0x71, each OR 0x80 when dp is set. When ACTIVE_LOW_OUT=1, sel_led and led_value are bitwise inverted.
- Dark means sel_led all inactive and led_value all segments off.

## Timing
- Reset values:
  - state OFF; prescaler, digit_idx, pending and active all 0.
  - frame_done 0.
  - sel_led and led_value dark: all-ones when ACTIVE_LOW_OUT=1, all-zeros when 0.
- All outputs are registered. Pins reflect the FSM state one cycle after the state is entered.
- From enable rising: digit 0 is lit on the pins 2 cycles later.
- Digit period = PRESCALE+GAP_CYCLES; frame = DIGITS·(PRESCALE+GAP_CYCLES).
- A load is visible no earlier than the first SHOW of the next frame. The only exception is a load while OFF, which is visible on the first SHOW.
- From enable falling: pins are dark 2 cycles later, and no frame_done pulses.
- Asserting reset mid-frame clears everything immediately (async); release is synchronous to the next clock edge.

## Configuration
- DISPLAY_LZ_BLANK_EN defined:
  - Leading-zero suppression is active. Starting from digit DIGITS-1 downward, a digit is dark while its nibble is 0 and its dp is 0. This holds for it and every more-significant digit.
  - Digit 0 is never suppressed.
  - A suppressed digit still occupies its SHOW slot: anode inactive, timing unchanged.
- Undefined: every digit is always shown, including zeros.

## Test plan
- DIGITS=4, PRESCALE=3, GAP_CYCLES=1, ACTIVE_LOW_OUT=1; reset low then release, enable=1 → sel_led=4'b1111 and led_value=8'hFF until cycle 2. Then sel_led=4'b1110 for 3 cycles, 4'b1111 for 1, then 4'b1101. frame_done pulses every 16 cycles.
- load bcds=16'h1A80, dp=4'b0100 mid-frame → old values persist to frame end. The next frame shows:
  - digit0 = 0x3F inverted = 0xC0
  - digit1 = 0x7F inverted = 0x80
  - digit2 = 0xF7 inverted = 0x08
  - digit3 = 0x06 inverted = 0xF9
- load asserted exactly on the frame_done cycle with bcds=16'h0005 → the next frame displays 0005 with no one-frame lag.
- With DISPLAY_LZ_BLANK_EN, bcds=16'h0050 and dp=0 → digits 3 and 2 stay dark during their slots; digits 1 and 0 show 5 and 0. Without the macro → all four are lit, showing "0050".
- enable dropped during digit 2 SHOW → dark 2 cycles later; digit_idx=0. Re-enable restarts at digit 0 with a full PRESCALE.
- reset asserted during GAP → outputs dark asynchronously and pending/active cleared; after release and enable, all digits show 0.
